// File: rtl/chunked_addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle with a registered carry,
// valid/ready on both sides, one operation in flight at a time.
module chunked_addsub_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    // Handshakes: a transfer happens on any rising edge where valid && ready.
    // in_ready is high only in IDLE, out_valid only in DONE, so ops never overlap.
    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operands shift right each RUN cycle so the active chunk is always at the bottom.
    assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry};
    assign msb_cin   = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (int'(idx) == k) sum[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    end
                    carry <= chunk_sum[CHUNK];
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    if (idx == LAST_IDX) begin
                        cout  <= chunk_sum[CHUNK];
                        ovf   <= chunk_sum[CHUNK] ^ msb_cin;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
